// File: rtl/esc_pkg.sv
// Shared ESC definitions: default widths and timing constants, plus the
// compare-value calculation reused by every ESC pulse generator.
package esc_pkg;

  localparam int unsigned ESC_NUM_CH      = 4;
  localparam int unsigned ESC_SPEED_W     = 11;
  localparam int unsigned ESC_OFF_W       = 10;
  localparam int unsigned ESC_SHIFT       = 4;
  localparam int unsigned ESC_PERIOD_W    = 20;
  localparam int unsigned ESC_BASE_CNT    = 50000;
  localparam int unsigned ESC_MAX_CMP     = 100000;
  localparam int unsigned ESC_WDOG_FRAMES = 8;
  localparam int unsigned ESC_CMP_W       = 32;

  // Pulse width in clocks: base + ((speed + off) << shift), clamped to max_cmp.
  // Inputs are zero-extended to 32 bits, wide enough that nothing overflows.
  function automatic logic [ESC_CMP_W-1:0] esc_calc_cmp(
    input logic [31:0] speed,
    input logic [31:0] off,
    input int unsigned shift,
    input logic [31:0] base_cnt,
    input logic [31:0] max_cmp
  );
    logic [31:0] sum;
    logic [31:0] cmp;
    sum = speed + off;
    cmp = base_cnt + (sum << shift);
    if (cmp > max_cmp) begin
      cmp = max_cmp;
    end
    return cmp;
  endfunction

endpackage

// File: rtl/esc_pwm_chan.sv
// One ESC channel: shadow/active compare registers, update watchdog and the
// registered pulse output. Frame timing comes from the shared counter in the top.
module esc_pwm_chan
  import esc_pkg::*;
#(
  parameter int unsigned SPEED_W     = ESC_SPEED_W,
  parameter int unsigned OFF_W       = ESC_OFF_W,
  parameter int unsigned SHIFT       = ESC_SHIFT,
  parameter int unsigned PERIOD_W    = ESC_PERIOD_W,
  parameter int unsigned BASE_CNT    = ESC_BASE_CNT,
  parameter int unsigned MAX_CMP     = ESC_MAX_CMP,
  parameter int unsigned WDOG_FRAMES = ESC_WDOG_FRAMES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boundary_i,
  input  logic                wr_en_i,
  input  logic [SPEED_W-1:0]  speed_i,
  input  logic [OFF_W-1:0]    off_i,
  input  logic                armed_d_i,
  input  logic [PERIOD_W-1:0] cnt_d_i,
  output logic                pwm_o,
  output logic                stale_o
);

  localparam logic [PERIOD_W-1:0] BASE     = PERIOD_W'(BASE_CNT);
  localparam logic [3:0]          WDOG_LIM = 4'(WDOG_FRAMES);

  logic [PERIOD_W-1:0] cmp_w;
  logic [PERIOD_W-1:0] shadow_q, shadow_d;
  logic [PERIOD_W-1:0] active_q, active_d;
  logic [3:0]          wdog_q, wdog_d, wdog_inc;
  logic                stale_q, stale_d;
  logic                force_base;
  logic                pwm_q, pwm_d;

  // The clamp keeps the result below 2**PERIOD_W, so truncation is lossless.
  assign cmp_w = PERIOD_W'(esc_calc_cmp(32'(speed_i), 32'(off_i), SHIFT,
                                        BASE_CNT, MAX_CMP));

  // Next-state: writes refresh the shadow and watchdog at once; the active
  // compare only moves at the frame boundary, taking the pre-write shadow.
  always_comb begin
    shadow_d   = wr_en_i ? cmp_w : shadow_q;
    wdog_inc   = (wdog_q == WDOG_LIM) ? wdog_q : wdog_q + 4'd1;
    wdog_d     = wdog_q;
    stale_d    = stale_q;
    active_d   = active_q;
    force_base = 1'b0;
    if (wr_en_i) begin
      wdog_d  = 4'd0;
      stale_d = 1'b0;
    end
    if (boundary_i) begin
      if (!wr_en_i) begin
        wdog_d = wdog_inc;
        if (wdog_inc == WDOG_LIM) begin
          force_base = 1'b1;
          stale_d    = 1'b1;
        end
      end
      active_d = force_base ? BASE : shadow_q;
    end
    pwm_d = armed_d_i && (cnt_d_i < active_d);
  end

  // Channel state; reset drops the pulse immediately and restores idle throttle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= BASE;
      active_q <= BASE;
      wdog_q   <= 4'd0;
      stale_q  <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      wdog_q   <= wdog_d;
      stale_q  <= stale_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign stale_o = stale_q;

endmodule

// File: rtl/esc_pwm_multi.sv
// Multi-channel ESC PWM generator: one free-running frame counter, frame-aligned
// arming and NUM_CH independent channels updated glitch-free at frame boundaries.
module esc_pwm_multi
  import esc_pkg::*;
#(
  parameter int unsigned NUM_CH      = ESC_NUM_CH,
  parameter int unsigned SPEED_W     = ESC_SPEED_W,
  parameter int unsigned OFF_W       = ESC_OFF_W,
  parameter int unsigned SHIFT       = ESC_SHIFT,
  parameter int unsigned PERIOD_W    = ESC_PERIOD_W,
  parameter int unsigned BASE_CNT    = ESC_BASE_CNT,
  parameter int unsigned MAX_CMP     = ESC_MAX_CMP,
  parameter int unsigned WDOG_FRAMES = ESC_WDOG_FRAMES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic [NUM_CH-1:0]         wr_en,
  input  logic [NUM_CH*SPEED_W-1:0] speed,
  input  logic [NUM_CH*OFF_W-1:0]   off,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      frame_start,
  output logic                      armed,
  output logic [NUM_CH-1:0]         stale
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                boundary;
  logic                armed_q, armed_d;
  logic                frame_start_q;

  // The last count of a frame is the only point where arm and compares change.
  assign boundary = &cnt_q;
  assign cnt_d    = cnt_q + PERIOD_W'(1);
  assign armed_d  = boundary ? arm : armed_q;

  // Frame counter, arm state and the one-cycle frame-start marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      frame_start_q <= boundary;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    esc_pwm_chan #(
      .SPEED_W    (SPEED_W),
      .OFF_W      (OFF_W),
      .SHIFT      (SHIFT),
      .PERIOD_W   (PERIOD_W),
      .BASE_CNT   (BASE_CNT),
      .MAX_CMP    (MAX_CMP),
      .WDOG_FRAMES(WDOG_FRAMES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .boundary_i(boundary),
      .wr_en_i   (wr_en[i]),
      .speed_i   (speed[i*SPEED_W +: SPEED_W]),
      .off_i     (off[i*OFF_W +: OFF_W]),
      .armed_d_i (armed_d),
      .cnt_d_i   (cnt_d),
      .pwm_o     (pwm[i]),
      .stale_o   (stale[i])
    );
  end

  assign frame_start = frame_start_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_esc_pwm_multi.sv
// Directed bench for esc_pwm_multi with a short 256-clock frame.
// Pulse widths per channel are counted over whole frames and compared with
// hand-computed values of 40 + ((speed+off) << 2), clamped to 200.
module tb_esc_pwm_multi;

  localparam int NUM_CH      = 4;
  localparam int SPEED_W     = 6;
  localparam int OFF_W       = 5;
  localparam int SHIFT       = 2;
  localparam int PERIOD_W    = 8;
  localparam int BASE_CNT    = 40;
  localparam int MAX_CMP     = 200;
  localparam int WDOG_FRAMES = 4;
  localparam int FRAME       = 1 << PERIOD_W;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      arm = 1'b0;
  logic [NUM_CH-1:0]         wr_en = '0;
  logic [NUM_CH*SPEED_W-1:0] speed = '0;
  logic [NUM_CH*OFF_W-1:0]   off = '0;
  logic [NUM_CH-1:0]         pwm;
  logic                      frame_start;
  logic                      armed;
  logic [NUM_CH-1:0]         stale;

  int n_cmp = 0;
  int n_bad = 0;

  int spd [NUM_CH];
  int ofs [NUM_CH];
  int w   [NUM_CH];
  logic [NUM_CH-1:0] ka_mask = '1;
  int   pend_ch  = -1;
  int   pend_cyc = -1;
  int   pend_spd = 0;
  int   pend_off = 0;
  int   arm_cyc  = -1;
  logic arm_val  = 1'b0;
  logic stale_after = 1'b1;

  always #5 clk = ~clk;

  esc_pwm_multi #(
    .NUM_CH     (NUM_CH),
    .SPEED_W    (SPEED_W),
    .OFF_W      (OFF_W),
    .SHIFT      (SHIFT),
    .PERIOD_W   (PERIOD_W),
    .BASE_CNT   (BASE_CNT),
    .MAX_CMP    (MAX_CMP),
    .WDOG_FRAMES(WDOG_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .wr_en      (wr_en),
    .speed      (speed),
    .off        (off),
    .pwm        (pwm),
    .frame_start(frame_start),
    .armed      (armed),
    .stale      (stale)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int c = 0; c < NUM_CH; c++) begin
      speed[c*SPEED_W +: SPEED_W] = SPEED_W'(spd[c]);
      off[c*OFF_W +: OFF_W]       = OFF_W'(ofs[c]);
    end
  endtask

  task automatic wait_fs();
    bit found;
    found = 1'b0;
    for (int i = 0; i < FRAME + 8; i++) begin
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) chk_eq("frame_start_timeout", 0, 1);
  endtask

  // Entered at the negedge of the cnt==0 cycle; leaves at the next one.
  task automatic measure_frame();
    logic [NUM_CH-1:0] m;
    chk_eq("frame_start_k0", 32'(frame_start), 1);
    for (int c = 0; c < NUM_CH; c++) w[c] = 0;
    for (int k = 0; k < FRAME; k++) begin
      for (int c = 0; c < NUM_CH; c++) if (pwm[c] === 1'b1) w[c]++;
      if (k == 1) chk_eq("frame_start_k1", 32'(frame_start), 0);
      if (pend_ch >= 0 && k == pend_cyc + 1) stale_after = stale[pend_ch];
      m = (k == 100) ? ka_mask : '0;
      if (pend_ch >= 0 && k == pend_cyc) begin
        spd[pend_ch] = pend_spd;
        ofs[pend_ch] = pend_off;
        m[pend_ch]   = 1'b1;
      end
      if (k == arm_cyc) arm = arm_val;
      drive_bus();
      wr_en = m;
      @(negedge clk);
    end
    wr_en   = '0;
    pend_ch = -1;
    arm_cyc = -1;
  endtask

  task automatic check_widths(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
    int e [NUM_CH];
    e = '{e0, e1, e2, e3};
    for (int c = 0; c < NUM_CH; c++)
      chk_eq($sformatf("%s_ch%0d", tag, c), w[c], e[c]);
  endtask

  initial begin
    int n;
    for (int c = 0; c < NUM_CH; c++) begin
      spd[c] = 0;
      ofs[c] = 0;
    end
    drive_bus();
    arm = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("rst_pwm", 32'(pwm), 0);
    chk_eq("rst_frame_start", 32'(frame_start), 0);
    chk_eq("rst_armed", 32'(armed), 0);
    chk_eq("rst_stale", 32'(stale), 0);
    rst = 1'b0;

    // ch0 5+0 -> 60, ch1 63+31 -> 416 clamped 200, ch2 10+0 -> 80, ch3 20+5 -> 140
    spd = '{5, 63, 10, 20};
    ofs = '{0, 31, 0, 5};
    drive_bus();
    wr_en = '1;
    @(negedge clk);
    wr_en = '0;
    wait_fs();

    measure_frame();
    check_widths("f1_init", 60, 200, 80, 140);
    chk_eq("f1_armed", 32'(armed), 1);
    chk_eq("f1_stale", 32'(stale), 0);

    // ch2 written mid-frame: 20+0 -> 120, visible only next frame
    pend_ch = 2; pend_cyc = 60; pend_spd = 20; pend_off = 0;
    measure_frame();
    check_widths("f2_midwr", 60, 200, 80, 140);

    // ch3 written in the boundary cycle: 0+10 -> 80, skips one frame
    pend_ch = 3; pend_cyc = FRAME - 1; pend_spd = 0; pend_off = 10;
    measure_frame();
    check_widths("f3_bwr", 60, 200, 120, 140);

    // disarm at cnt 20: pulses of this frame still complete
    arm_cyc = 20; arm_val = 1'b0;
    measure_frame();
    check_widths("f4_disarm", 60, 200, 120, 140);
    chk_eq("f4_armed_after", 32'(armed), 0);

    // rearm mid-frame: no runt pulse this frame
    arm_cyc = 128; arm_val = 1'b1;
    measure_frame();
    check_widths("f5_off", 0, 0, 0, 0);
    chk_eq("f5_armed_after", 32'(armed), 1);

    // stop refreshing ch0; watchdog trips at the fourth silent boundary
    ka_mask = 4'b1110;
    measure_frame();
    check_widths("f6_rearm", 60, 200, 120, 80);
    chk_eq("f6_stale", 32'(stale), 0);
    measure_frame();
    check_widths("f7", 60, 200, 120, 80);
    chk_eq("f7_stale", 32'(stale), 0);
    measure_frame();
    check_widths("f8", 60, 200, 120, 80);
    chk_eq("f8_stale_trip", 32'(stale), 1);

    // stale ch0 runs at base width; a write clears stale on the next clock
    pend_ch = 0; pend_cyc = 50; pend_spd = 5; pend_off = 0;
    measure_frame();
    check_widths("f9_stale", 40, 200, 120, 80);
    chk_eq("f9_stale_clear", 32'(stale_after), 0);
    chk_eq("f9_stale_end", 32'(stale), 0);
    ka_mask = '1;
    measure_frame();
    check_widths("f10_restore", 60, 200, 120, 80);

    // asynchronous reset in the middle of the pulses
    repeat (30) @(negedge clk);
    chk_eq("pre_rst_pwm", 32'(pwm), 32'(4'b1111));
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_pwm", 32'(pwm), 0);
    chk_eq("mid_rst_armed", 32'(armed), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= FRAME + 8; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        n = i;
        break;
      end
    end
    chk_eq("rst_frame_restart", n, FRAME);
    measure_frame();
    check_widths("post_rst_base", 40, 40, 40, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
